decoder_bintohex_pulse: RTL and testbench

Sequential 4-to-16 binary-to-one-hot decoder with a valid/ready input handshake and timed output pulses. Each accepted 4-bit code drives exactly one of 16 output lines high for a programmable number of cycles, followed by a programmable idle gap. It sits downstream of the 16-to-4 encoders and drives one-hot select, strobe or scan lines from compact binary indices.

---
 rtl/decoder_bintohex_pulse_if.sv | 38 +++
 rtl/decoder_bintohex_pulse.sv | 158 +++++++++++++++
 tb/tb_decoder_bintohex_pulse.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_bintohex_pulse_if.sv
// ----------------------------------------------------------------------------
// decoder_bintohex_pulse_if
// Handshake and output bundle for decoder_bintohex_pulse.
//   in_valid  producer -> decoder  in_code is valid this cycle
//   in_ready  decoder  -> producer decoder can accept a code this cycle
//   in_code   producer -> decoder  4-bit binary index 0..15
//   out       decoder  -> consumer 16-bit one-hot line, zero when idle/gap
//   busy      decoder  -> consumer high while driving a pulse or its gap
//   done      decoder  -> consumer one-cycle strobe in the last pulse cycle
// master: the producer/consumer side (a bench or upstream logic).
// slave : the decoder itself.
// ----------------------------------------------------------------------------
interface decoder_bintohex_pulse_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_code;
    logic [15:0] out;
    logic        busy;
    logic        done;

    modport master (
        output in_valid,
        output in_code,
        input  in_ready,
        input  out,
        input  busy,
        input  done
    );

    modport slave (
        input  in_valid,
        input  in_code,
        output in_ready,
        output out,
        output busy,
        output done
    );
endinterface

// File: rtl/decoder_bintohex_pulse.sv
// ----------------------------------------------------------------------------
// decoder_bintohex_pulse
// Sequential 4-to-16 binary-to-one-hot decoder. Each accepted code drives one
// output line high for PULSE_LEN cycles, followed by GAP_LEN all-zero cycles.
//
// Parameters:
//   PULSE_LEN  cycles each one-hot pulse is held (1..255)
//   GAP_LEN    all-zero cycles after each pulse   (0..255)
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  decoder_bintohex_pulse_if.slave (in_valid/in_ready/in_code,
//        out, busy, done)
//
// Build option:
//   DECODER_PULSE_BUF_EN  when defined, adds a one-entry input buffer so a
//                         code accepted while busy starts right after the
//                         current pulse/gap with no IDLE cycle in between.
// ----------------------------------------------------------------------------
module decoder_bintohex_pulse #(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    decoder_bintohex_pulse_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Counter reload values; the gap reload is only used when GAP_LEN > 0.
    localparam logic [7:0] PULSE_CNT = 8'(PULSE_LEN - 1);
    localparam logic [7:0] GAP_CNT   = (GAP_LEN > 0) ? 8'(GAP_LEN - 1) : 8'd0;

    state_t     state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [3:0] code_q,  code_d;
    logic       accept;
    logic       period_end;

`ifdef DECODER_PULSE_BUF_EN
    logic       buf_valid_q, buf_valid_d;
    logic [3:0] buf_code_q,  buf_code_d;
`endif

    // ------------------------------------------------------------------
    // Outputs: all derived from registered state, never from in_valid.
    // ------------------------------------------------------------------
`ifdef DECODER_PULSE_BUF_EN
    assign bus.in_ready = (state_q == IDLE) || !buf_valid_q;
`else
    assign bus.in_ready = (state_q == IDLE);
`endif

    assign accept   = bus.in_valid && bus.in_ready;
    assign bus.out  = (state_q == DRIVE) ? (16'h0001 << code_q) : 16'h0000;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DRIVE) && (cnt_q == 8'd0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch so no
        // path leaves it unassigned; otherwise synthesis infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        period_end = 1'b0;
`ifdef DECODER_PULSE_BUF_EN
        buf_valid_d = buf_valid_q;
        buf_code_d  = buf_code_q;
        // While busy, an accepted code parks in the buffer; in IDLE it
        // bypasses the buffer and starts immediately below.
        if (accept && (state_q != IDLE)) begin
            buf_valid_d = 1'b1;
            buf_code_d  = bus.in_code;
        end
`endif

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    code_d  = bus.in_code;
                    cnt_d   = PULSE_CNT;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (GAP_LEN == 0) begin
                    period_end = 1'b1;
                end else begin
                    cnt_d   = GAP_CNT;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    period_end = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        // End of a full pulse period: return to IDLE unless a code is
        // waiting (including one accepted on this very edge).
        if (period_end) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
`ifdef DECODER_PULSE_BUF_EN
            if (buf_valid_d) begin
                state_d     = DRIVE;
                code_d      = buf_code_d;
                cnt_d       = PULSE_CNT;
                buf_valid_d = 1'b0;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values; blocking here would create order-dependent races.
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            code_q      <= 4'd0;
`ifdef DECODER_PULSE_BUF_EN
            buf_valid_q <= 1'b0;
            buf_code_q  <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
`ifdef DECODER_PULSE_BUF_EN
            buf_valid_q <= buf_valid_d;
            buf_code_q  <= buf_code_d;
`endif
        end
    end

endmodule

// File: tb/tb_decoder_bintohex_pulse.sv
// ----------------------------------------------------------------------------
// tb_decoder_bintohex_pulse
// Self-checking bench for decoder_bintohex_pulse. Two instances:
//   dut_a  PULSE_LEN=4, GAP_LEN=1  (main behaviour, scoreboarded pulses)
//   dut_b  PULSE_LEN=1, GAP_LEN=0  (single-cycle pulse corner)
// Accepted codes are queued on transfer; a negedge monitor on dut_a closes
// each observed pulse and compares it with the oldest queued code.
// ----------------------------------------------------------------------------
module tb_decoder_bintohex_pulse;

    localparam int PULSE_A = 4;
    localparam int GAP_A   = 1;

`ifdef DECODER_PULSE_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    decoder_bintohex_pulse_if bus_a ();
    decoder_bintohex_pulse_if bus_b ();

    decoder_bintohex_pulse #(.PULSE_LEN(PULSE_A), .GAP_LEN(GAP_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    decoder_bintohex_pulse #(.PULSE_LEN(1), .GAP_LEN(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Pulse monitor for dut_a
    // ------------------------------------------------------------------
    logic        mon_en = 1'b0;
    logic [15:0] run_val = '0;
    int          run_len = 0;
    int          done_cnt = 0;
    int          done_pos = 0;

    always @(negedge clk) begin
        if (!mon_en || rst) begin
            run_len  = 0;
            done_cnt = 0;
            done_pos = 0;
        end else begin
            if (run_len != 0 && bus_a.out != run_val) begin
                check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    logic [3:0] c;
                    c = exp_q.pop_front();
                    check("pulse_value", 32'(run_val), 32'h1 << c);
                end
                check("pulse_len", 32'(run_len), 32'(PULSE_A));
                check("done_count", 32'(done_cnt), 32'd1);
                check("done_pos", 32'(done_pos), 32'(PULSE_A));
                run_len  = 0;
                done_cnt = 0;
                done_pos = 0;
            end
            if (bus_a.out != 16'h0000) begin
                if (run_len == 0) run_val = bus_a.out;
                run_len++;
                if (bus_a.done) begin
                    done_cnt++;
                    done_pos = run_len;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at #1 after a rising edge)
    // ------------------------------------------------------------------
    task automatic send_a(input logic [3:0] c);
        int k = 0;
        while (!bus_a.in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("a_ready_wait", 32'(bus_a.in_ready), 32'd1);
        bus_a.in_valid = 1'b1;
        bus_a.in_code  = c;
        @(posedge clk);
        exp_q.push_back(c);
        #1;
        bus_a.in_valid = 1'b0;
    endtask

    task automatic wait_idle_a();
        int k = 0;
        while (bus_a.busy && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("a_idle_wait", 32'(bus_a.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus_a.in_valid = 1'b0;
        bus_a.in_code  = 4'd0;
        bus_b.in_valid = 1'b0;
        bus_b.in_code  = 4'd0;

        // ---- Reset state ----
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_a",   32'(bus_a.out),      32'h0000);
        check("rst_ready_a", 32'(bus_a.in_ready), 32'd1);
        check("rst_busy_a",  32'(bus_a.busy),     32'd0);
        check("rst_done_a",  32'(bus_a.done),     32'd0);
        check("rst_out_b",   32'(bus_b.out),      32'h0000);
        check("rst_ready_b", 32'(bus_b.in_ready), 32'd1);
        mon_en = 1'b1;

        // ---- Code 0: 4 drive cycles, done in the 4th, 1 gap, then idle ----
        send_a(4'd0);
        for (int i = 0; i < PULSE_A; i++) begin
            check("t1_out",   32'(bus_a.out),      32'h0001);
            check("t1_done",  32'(bus_a.done),     32'(i == PULSE_A - 1));
            check("t1_busy",  32'(bus_a.busy),     32'd1);
            check("t1_ready", 32'(bus_a.in_ready), 32'(BUF_EN));
            @(posedge clk); #1;
        end
        check("t1_gap_out",  32'(bus_a.out),  32'h0000);
        check("t1_gap_busy", 32'(bus_a.busy), 32'd1);
        @(posedge clk); #1;
        check("t1_idle_ready", 32'(bus_a.in_ready), 32'd1);
        check("t1_idle_busy",  32'(bus_a.busy),     32'd0);

        // ---- Sweep all 16 codes, scoreboarded by the monitor ----
        for (int c = 0; c < 16; c++) send_a(4'(c));
        wait_idle_a();

        // ---- in_valid held high with code 9 while busy ----
        bus_a.in_valid = 1'b1;
        bus_a.in_code  = 4'd9;
        @(posedge clk);
        exp_q.push_back(4'd9);
        #1;
        k = 1;
        while (!bus_a.in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("hold_ready_after", 32'(k), BUF_EN ? 32'd1 : 32'(PULSE_A + GAP_A + 1));
        @(posedge clk);
        exp_q.push_back(4'd9);
        #1;
        bus_a.in_valid = 1'b0;
        wait_idle_a();

        // ---- PULSE_LEN=1, GAP_LEN=0, code 15 on dut_b ----
        bus_b.in_valid = 1'b1;
        bus_b.in_code  = 4'd15;
        @(posedge clk); #1;
        bus_b.in_valid = 1'b0;
        check("b_out",  32'(bus_b.out),  32'h8000);
        check("b_done", 32'(bus_b.done), 32'd1);
        check("b_busy", 32'(bus_b.busy), 32'd1);
        check("b_ready_drive", 32'(bus_b.in_ready), 32'(BUF_EN));
        @(posedge clk); #1;
        check("b_out_after",   32'(bus_b.out),      32'h0000);
        check("b_ready_after", 32'(bus_b.in_ready), 32'd1);
        check("b_done_after",  32'(bus_b.done),     32'd0);

        // ---- Reset during 2nd DRIVE cycle of code 5 ----
        mon_en = 1'b0;
        bus_a.in_valid = 1'b1;
        bus_a.in_code  = 4'd5;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_pre_out", 32'(bus_a.out), 32'h0020);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_out",   32'(bus_a.out),      32'h0000);
        check("abort_busy",  32'(bus_a.busy),     32'd0);
        check("abort_ready", 32'(bus_a.in_ready), 32'd1);
        check("abort_done",  32'(bus_a.done),     32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_resume", 32'(bus_a.out), 32'h0000);

        // ---- rst and in_valid together: reset wins ----
        rst = 1'b1;
        bus_a.in_valid = 1'b1;
        bus_a.in_code  = 4'd7;
        @(posedge clk); #1;
        rst = 1'b0;
        bus_a.in_valid = 1'b0;
        check("rst_valid_busy", 32'(bus_a.busy), 32'd0);
        @(posedge clk); #1;
        check("rst_valid_out", 32'(bus_a.out), 32'h0000);
        mon_en = 1'b1;

`ifdef DECODER_PULSE_BUF_EN
        // ---- Codes 3 then 12 back-to-back: 12 buffered, no IDLE between ----
        send_a(4'd3);
        check("buf_ready_empty", 32'(bus_a.in_ready), 32'd1);
        bus_a.in_valid = 1'b1;
        bus_a.in_code  = 4'd12;
        @(posedge clk);
        exp_q.push_back(4'd12);
        #1;
        bus_a.in_valid = 1'b0;
        check("buf_ready_full", 32'(bus_a.in_ready), 32'd0);
        for (int i = 1; i < PULSE_A; i++) begin
            check("buf_out_3", 32'(bus_a.out), 32'h0008);
            @(posedge clk); #1;
        end
        check("buf_gap", 32'(bus_a.out), 32'h0000);
        @(posedge clk); #1;
        for (int i = 0; i < PULSE_A; i++) begin
            check("buf_out_12", 32'(bus_a.out), 32'h1000);
            @(posedge clk); #1;
        end
        check("buf_gap2", 32'(bus_a.out), 32'h0000);
`endif

        wait_idle_a();
        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
